// File: rtl/basic_ctrl_pkg.sv
// rtl/basic_ctrl_pkg.sv - opcode, ALU code, register-reference and FSM constants for the basic computer sequencer
package basic_ctrl_pkg;

    // Memory-reference opcodes, IR[14:12]
    localparam logic [2:0] OP_AND    = 3'd0;
    localparam logic [2:0] OP_ADD    = 3'd1;
    localparam logic [2:0] OP_LDA    = 3'd2;
    localparam logic [2:0] OP_STA    = 3'd3;
    localparam logic [2:0] OP_BUN    = 3'd4;
    localparam logic [2:0] OP_BSA    = 3'd5;
    localparam logic [2:0] OP_ISZ    = 3'd6;
    localparam logic [2:0] OP_REGREF = 3'd7;

    // ALU operation codes; AND/ADD/LOAD_DR share their encoding with the opcodes above
    localparam logic [2:0] ALU_AND     = 3'd0;
    localparam logic [2:0] ALU_ADD     = 3'd1;
    localparam logic [2:0] ALU_LOAD_DR = 3'd2;
    localparam logic [2:0] ALU_CMA     = 3'd3;
    localparam logic [2:0] ALU_SHR     = 3'd4;
    localparam logic [2:0] ALU_SHL     = 3'd5;
    localparam logic [2:0] ALU_PASS    = 3'd6;
    localparam logic [2:0] ALU_ZERO    = 3'd7;

    // Register-reference bit positions in IR[11:0]; a higher bit wins
    localparam int RR_CLA = 11;
    localparam int RR_CLE = 10;
    localparam int RR_CMA = 9;
    localparam int RR_CME = 8;
    localparam int RR_CIR = 7;
    localparam int RR_CIL = 6;
    localparam int RR_INC = 5;
    localparam int RR_SPA = 4;
    localparam int RR_SNA = 3;
    localparam int RR_SZA = 2;
    localparam int RR_SZE = 1;
    localparam int RR_HLT = 0;

    // Sequencer states
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_INDIRECT = 4'd3;
    localparam logic [3:0] S_OPERAND  = 4'd4;
    localparam logic [3:0] S_EXEC_ALU = 4'd5;
    localparam logic [3:0] S_WRITE    = 4'd6;
    localparam logic [3:0] S_REGREF   = 4'd7;
    localparam logic [3:0] S_HALT     = 4'd8;

    // Control produced by the register-reference decoder
    typedef struct packed {
        logic       ac_we;
        logic       e_clr;
        logic       e_cmp;
        logic       e_from_alu;
        logic       skip;
        logic       hlt;
        logic [2:0] alu_op;
    } rr_ctrl_t;

endpackage

// File: rtl/basic_ctrl_regref_decode.sv
// rtl/basic_ctrl_regref_decode.sv - priority decode of a register-reference instruction into action, ALU op and skip
module basic_ctrl_regref_decode
    import basic_ctrl_pkg::*;
(
    input  logic [11:0] rr_bits,
    input  logic        e,
    input  logic        alu_n,
    input  logic        alu_z,
    output logic [11:0] action,
    output rr_ctrl_t    ctrl
);

    // Keep only the highest set bit; all-zero means NOP
    always_comb begin
        action = '0;
        for (int i = 0; i < 12; i++) begin
            if (rr_bits[i]) begin
                action = 12'd1 << i;
            end
        end
    end

    // Translate the one-hot action into ALU op, register writes and skip condition
    always_comb begin
        ctrl        = '0;
        ctrl.alu_op = ALU_ZERO;
        if (action[RR_CLA]) begin
            ctrl.ac_we = 1'b1;
        end
        if (action[RR_CLE]) begin
            ctrl.e_clr = 1'b1;
        end
        if (action[RR_CMA]) begin
            ctrl.ac_we  = 1'b1;
            ctrl.alu_op = ALU_CMA;
        end
        if (action[RR_CME]) begin
            ctrl.e_cmp = 1'b1;
        end
        if (action[RR_CIR]) begin
            ctrl.ac_we      = 1'b1;
            ctrl.e_from_alu = 1'b1;
            ctrl.alu_op     = ALU_SHR;
        end
        if (action[RR_CIL]) begin
            ctrl.ac_we      = 1'b1;
            ctrl.e_from_alu = 1'b1;
            ctrl.alu_op     = ALU_SHL;
        end
        if (action[RR_INC]) begin
            ctrl.ac_we  = 1'b1;
            ctrl.alu_op = ALU_ADD;
        end
        if (action[RR_SPA]) begin
            ctrl.skip = ~alu_n & ~alu_z;
        end
        if (action[RR_SNA]) begin
            ctrl.skip = alu_n;
        end
        if (action[RR_SZA]) begin
            ctrl.skip = alu_z;
        end
        if (action[RR_SZE]) begin
            ctrl.skip = ~e;
        end
        if (action[RR_HLT]) begin
            ctrl.hlt = 1'b1;
        end
    end

endmodule

// File: rtl/basic_ctrl_sequencer.sv
// rtl/basic_ctrl_sequencer.sv - instruction-cycle controller for the 16-bit basic computer; optional retire trace under BASIC_CTRL_RETIRE_TRACE_EN
module basic_ctrl_sequencer
    import basic_ctrl_pkg::*;
#(
    parameter int W  = 16,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [W-1:0]  mem_wdata,
    input  logic [W-1:0]  mem_rdata,
    input  logic          mem_ack,
    output logic [2:0]    alu_op_select,
    output logic [W-1:0]  alu_ac,
    output logic [W-1:0]  alu_dr,
    output logic          alu_e,
    input  logic [W-1:0]  alu_out,
    input  logic          alu_e_next,
    input  logic          alu_n,
    input  logic          alu_z,
    output logic          halted,
    output logic          busy
`ifdef BASIC_CTRL_RETIRE_TRACE_EN
    ,
    output logic          retire_valid,
    output logic [AW-1:0] retire_pc,
    output logic [W-1:0]  retire_ir
`endif
);

    logic [3:0]    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d, ar_q, ar_d;
    logic [W-1:0]  ir_q, ir_d, dr_q, dr_d, ac_q, ac_d;
    logic          e_q, e_d, mem_req_q, mem_req_d;
    logic [2:0]    opcode;
    logic          acked, mem_state;
    logic [11:0]   rr_action;
    rr_ctrl_t      rr;

    assign opcode    = ir_q[14:12];
    assign acked     = mem_req_q & mem_ack;
    // BUN is the only memory-reference instruction that needs no operand access
    assign mem_state = (state_q == S_FETCH) || (state_q == S_INDIRECT) || (state_q == S_WRITE) ||
                       ((state_q == S_OPERAND) && (opcode != OP_BUN));

    basic_ctrl_regref_decode u_regref_decode (
        .rr_bits (ir_q[11:0]),
        .e       (e_q),
        .alu_n   (alu_n),
        .alu_z   (alu_z),
        .action  (rr_action),
        .ctrl    (rr)
    );

    // Register update; rst also drops any outstanding memory request
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            ar_q      <= '0;
            ir_q      <= '0;
            dr_q      <= '0;
            ac_q      <= '0;
            e_q       <= 1'b0;
            mem_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ar_q      <= ar_d;
            ir_q      <= ir_d;
            dr_q      <= dr_d;
            ac_q      <= ac_d;
            e_q       <= e_d;
            mem_req_q <= mem_req_d;
        end
    end

    // Fetch/decode/execute sequencing; a memory state raises req on entry and drops it after ack
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ar_d      = ar_q;
        ir_d      = ir_q;
        dr_d      = dr_q;
        ac_d      = ac_q;
        e_d       = e_q;
        mem_req_d = mem_req_q;
        if (mem_state) begin
            if (!mem_req_q) begin
                mem_req_d = 1'b1;
            end else if (mem_ack) begin
                mem_req_d = 1'b0;
            end
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (acked) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + AW'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ar_d = ir_q[AW-1:0];
                if (opcode == OP_REGREF) begin
                    state_d = S_REGREF;
                end else if (ir_q[15]) begin
                    state_d = S_INDIRECT;
                end else begin
                    state_d = S_OPERAND;
                end
            end
            S_INDIRECT: begin
                if (acked) begin
                    ar_d    = mem_rdata[AW-1:0];
                    state_d = S_OPERAND;
                end
            end
            S_OPERAND: begin
                case (opcode)
                    OP_BUN: begin
                        pc_d    = ar_q;
                        state_d = S_FETCH;
                    end
                    OP_STA: begin
                        if (acked) begin
                            state_d = S_FETCH;
                        end
                    end
                    OP_BSA: begin
                        if (acked) begin
                            pc_d    = ar_q + AW'(1);
                            state_d = S_FETCH;
                        end
                    end
                    OP_ISZ: begin
                        if (acked) begin
                            dr_d    = mem_rdata + W'(1);
                            state_d = S_WRITE;
                        end
                    end
                    default: begin
                        if (acked) begin
                            dr_d    = mem_rdata;
                            state_d = S_EXEC_ALU;
                        end
                    end
                endcase
            end
            S_EXEC_ALU: begin
                ac_d = alu_out;
                if (opcode == OP_ADD) begin
                    e_d = alu_e_next;
                end
                state_d = S_FETCH;
            end
            S_WRITE: begin
                if (acked) begin
                    if (dr_q == '0) begin
                        pc_d = pc_q + AW'(1);
                    end
                    state_d = S_FETCH;
                end
            end
            S_REGREF: begin
                if (rr.ac_we) begin
                    ac_d = alu_out;
                end
                if (rr.e_clr) begin
                    e_d = 1'b0;
                end
                if (rr.e_cmp) begin
                    e_d = ~e_q;
                end
                if (rr.e_from_alu) begin
                    e_d = alu_e_next;
                end
                if (rr.skip) begin
                    pc_d = pc_q + AW'(1);
                end
                state_d = rr.hlt ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs; mem_addr shows PC whenever AR is not the access address, so PC is visible when idle or halted
    always_comb begin
        mem_req   = mem_req_q;
        mem_we    = (state_q == S_WRITE) ||
                    ((state_q == S_OPERAND) && ((opcode == OP_STA) || (opcode == OP_BSA)));
        mem_addr  = ((state_q == S_INDIRECT) || (state_q == S_OPERAND) || (state_q == S_WRITE)) ? ar_q : pc_q;
        mem_wdata = (state_q == S_WRITE) ? dr_q : ((opcode == OP_BSA) ? W'(pc_q) : ac_q);
        alu_op_select = ALU_ZERO;
        if (state_q == S_EXEC_ALU) begin
            alu_op_select = opcode;
        end else if (state_q == S_REGREF) begin
            alu_op_select = rr.alu_op;
        end
        alu_ac = ac_q;
        alu_dr = ((state_q == S_REGREF) && rr_action[RR_INC]) ? W'(1) : dr_q;
        alu_e  = e_q;
        halted = (state_q == S_HALT);
        busy   = (state_q != S_IDLE) && (state_q != S_HALT);
    end

`ifdef BASIC_CTRL_RETIRE_TRACE_EN
    logic [AW-1:0] ipc_q, ipc_d;

    // Remember the fetch address of the instruction in flight
    always_comb begin
        ipc_d = (state_q == S_FETCH) ? pc_q : ipc_q;
    end

    // Fetch-address register for the trace
    always_ff @(posedge clk) begin
        if (rst) begin
            ipc_q <= '0;
        end else begin
            ipc_q <= ipc_d;
        end
    end

    // An instruction retires on the cycle it hands over to the next fetch or to HALT
    always_comb begin
        retire_valid = busy && (state_q != S_FETCH) && ((state_d == S_FETCH) || (state_d == S_HALT));
        retire_pc    = ipc_q;
        retire_ir    = ir_q;
    end
`endif

endmodule

// File: tb/tb_basic_ctrl_sequencer.sv
// tb/tb_basic_ctrl_sequencer.sv - directed self-checking bench for basic_ctrl_sequencer
module tb_basic_ctrl_sequencer;

    localparam int W  = 16;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_wdata, mem_rdata;
    logic [2:0]    alu_op_select;
    logic [W-1:0]  alu_ac, alu_dr, alu_out;
    logic          alu_e, alu_e_next, alu_n, alu_z;
    logic          halted, busy;

    logic [W-1:0]  mem [0:4095];
    int            checks = 0;
    int            errors = 0;

    int            ack_delay = 0;
    bit            resp_en = 1'b1;
    bit            force_ack = 1'b0;
    int            wait_cnt = 0;
    int            n_reads = 0;
    int            n_writes = 0;
    bit            unstable = 1'b0;
    logic [AW-1:0] held_addr = '0;
    logic [AW-1:0] rd_log [0:7];
    logic [AW-1:0] last_waddr = '0;
    logic [W-1:0]  last_wdata = '0;

    basic_ctrl_sequencer #(.W(W), .AW(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .alu_op_select (alu_op_select),
        .alu_ac        (alu_ac),
        .alu_dr        (alu_dr),
        .alu_e         (alu_e),
        .alu_out       (alu_out),
        .alu_e_next    (alu_e_next),
        .alu_n         (alu_n),
        .alu_z         (alu_z),
        .halted        (halted),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // ALU stand-in; flags describe the AC input
    always_comb begin
        alu_out    = alu_ac;
        alu_e_next = alu_e;
        case (alu_op_select)
            3'b000: alu_out = alu_ac & alu_dr;
            3'b001: {alu_e_next, alu_out} = {1'b0, alu_ac} + {1'b0, alu_dr};
            3'b010: alu_out = alu_dr;
            3'b011: alu_out = ~alu_ac;
            3'b100: begin alu_out = {alu_e, alu_ac[15:1]}; alu_e_next = alu_ac[0]; end
            3'b101: begin alu_out = {alu_ac[14:0], alu_e}; alu_e_next = alu_ac[15]; end
            3'b110: alu_out = alu_ac;
            default: alu_out = '0;
        endcase
        alu_n = alu_ac[15];
        alu_z = (alu_ac == '0);
    end

    // Memory responder: acks after ack_delay wait cycles, logs accesses, flags request instability
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                wait_cnt = 0; n_reads = 0; n_writes = 0; unstable = 1'b0;
            end
            if (force_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = 16'h7001;
            end else if (!resp_en) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end else if (mem_req && !mem_ack) begin
                if (wait_cnt == 0) held_addr = mem_addr;
                else if (mem_addr != held_addr) unstable = 1'b1;
                wait_cnt++;
                if (wait_cnt > ack_delay) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        last_waddr = mem_addr;
                        last_wdata = mem_wdata;
                        n_writes++;
                    end else begin
                        mem_rdata = mem[mem_addr];
                        if (n_reads < 8) rd_log[n_reads] = mem_addr;
                        n_reads++;
                    end
                end
            end else begin
                if (!mem_ack && wait_cnt != 0 && !rst) unstable = 1'b1;
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = '0;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_prog(input string tag);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 1000 && !halted; i++) @(negedge clk);
        check_eq({tag, "_halted"}, halted, 1);
    endtask

    initial begin
        // Reset state
        clear_mem();
        do_reset();
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_halted", halted, 0);
        check_eq("rst_alu_op", alu_op_select, 3'b111);
        check_eq("rst_ac", alu_ac, 0);
        check_eq("rst_e", alu_e, 0);
        check_eq("rst_pc", mem_addr, 0);

        // LDA then HLT
        mem[0] = 16'h2010; mem[12'h010] = 16'h1234; mem[1] = 16'h7001;
        run_prog("lda");
        check_eq("lda_ac", alu_ac, 16'h1234);
        check_eq("lda_pc", mem_addr, 12'h002);
        check_eq("lda_busy", busy, 0);
        @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
        check_eq("halt_ignores_start", halted, 1);

        // ADD carry to zero, SZA skips
        clear_mem(); do_reset();
        mem[0] = 16'h2010; mem[1] = 16'h1011; mem[2] = 16'h7004; mem[3] = 16'h7001; mem[4] = 16'h7001;
        mem[12'h010] = 16'hFFFF; mem[12'h011] = 16'h0001;
        run_prog("add");
        check_eq("add_ac", alu_ac, 16'h0000);
        check_eq("add_e", alu_e, 1);
        check_eq("sza_pc", mem_addr, 12'h005);

        // Indirect LDA
        clear_mem(); do_reset();
        mem[0] = 16'hA020; mem[12'h020] = 16'h0030; mem[12'h030] = 16'hBEEF; mem[1] = 16'h7001;
        run_prog("ind");
        check_eq("ind_ac", alu_ac, 16'hBEEF);
        check_eq("ind_reads", n_reads, 4);
        check_eq("ind_rd0", rd_log[0], 12'h000);
        check_eq("ind_rd1", rd_log[1], 12'h020);
        check_eq("ind_rd2", rd_log[2], 12'h030);

        // ISZ wrap to zero skips, non-zero does not
        clear_mem(); do_reset();
        mem[0] = 16'h6040; mem[1] = 16'h7001; mem[2] = 16'h7001; mem[12'h040] = 16'hFFFF;
        run_prog("isz0");
        check_eq("isz0_waddr", last_waddr, 12'h040);
        check_eq("isz0_wdata", last_wdata, 16'h0000);
        check_eq("isz0_pc", mem_addr, 12'h003);
        mem[12'h040] = 16'h0005; do_reset();
        run_prog("isz5");
        check_eq("isz5_wdata", last_wdata, 16'h0006);
        check_eq("isz5_writes", n_writes, 1);
        check_eq("isz5_pc", mem_addr, 12'h002);

        // Slow memory: request and address hold until ack
        clear_mem(); do_reset(); ack_delay = 5;
        mem[0] = 16'h2010; mem[12'h010] = 16'h1234; mem[1] = 16'h7001;
        run_prog("slow");
        check_eq("slow_stable", unstable, 0);
        check_eq("slow_ac", alu_ac, 16'h1234);
        check_eq("slow_reads", n_reads, 3);

        // rst in the middle of the second fetch, then a late ack
        do_reset(); ack_delay = 20;
        @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
        for (int i = 0; i < 300 && !(mem_req && mem_addr == 12'h001); i++) @(negedge clk);
        check_eq("rst_mid_reached", {mem_req, mem_addr}, {1'b1, 12'h001});
        check_eq("rst_mid_ac_loaded", alu_ac, 16'h1234);
        repeat (3) @(negedge clk);
        resp_en = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_mid_req_drop", mem_req, 0);
        @(negedge clk); rst = 1'b0;
        check_eq("rst_mid_ac", alu_ac, 0);
        check_eq("rst_mid_dr", alu_dr, 0);
        check_eq("rst_mid_pc", mem_addr, 0);
        force_ack = 1'b1;
        repeat (3) @(negedge clk);
        force_ack = 1'b0;
        check_eq("late_ack_busy", busy, 0);
        check_eq("late_ack_req", mem_req, 0);
        check_eq("late_ack_halted", halted, 0);
        check_eq("late_ack_ac", alu_ac, 0);
        @(negedge clk); resp_en = 1'b1; ack_delay = 0;

        // BUN to 7, BSA 0x050
        clear_mem(); do_reset();
        mem[0] = 16'h4007; mem[7] = 16'h5050; mem[12'h051] = 16'h7001;
        run_prog("bsa");
        check_eq("bsa_waddr", last_waddr, 12'h050);
        check_eq("bsa_wdata", last_wdata, 16'h0008);
        check_eq("bsa_pc", mem_addr, 12'h052);

        // CIL rotates AC through E
        clear_mem(); do_reset();
        mem[0] = 16'h2010; mem[12'h010] = 16'h8001; mem[1] = 16'h7040; mem[2] = 16'h7001;
        run_prog("cil");
        check_eq("cil_ac", alu_ac, 16'h0002);
        check_eq("cil_e", alu_e, 1);

        // INC wraps without touching E
        clear_mem(); do_reset();
        mem[0] = 16'h2010; mem[12'h010] = 16'hFFFF; mem[1] = 16'h7020; mem[2] = 16'h7001;
        run_prog("inc");
        check_eq("inc_ac", alu_ac, 16'h0000);
        check_eq("inc_e", alu_e, 0);

        // CLA outranks HLT in the same word
        clear_mem(); do_reset();
        mem[0] = 16'h2010; mem[12'h010] = 16'h1234; mem[1] = 16'h7801; mem[2] = 16'h7001;
        run_prog("cla");
        check_eq("cla_ac", alu_ac, 16'h0000);
        check_eq("cla_pc", mem_addr, 12'h003);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
